mig_app_model: RTL and testbench

Synthesizable stand-in for the MIG user (app) interface: the responder end of the command/write-data/read-data protocol that the DDR control FSM drives. Lets the CPU-to-DDR path run in simulation and on boards without a DDR PHY. It emulates calibration delay, `app_rdy` back-pressure, write-data buffering, and fixed-latency in-order reads, all backed by an internal 128-bit-wide RAM.

---
 rtl/mig_app_model_pkg.sv | 10 +
 rtl/mig_app_model_wdf_fifo.sv | 48 ++++
 rtl/mig_app_model.sv | 173 +++++++++++++++++
 tb/tb_mig_app_model.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_app_model_pkg.sv
// Shared MIG app-interface definitions.
// Imported by the responder model and by the DDR control FSM.
package mig_app_model_pkg;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  typedef logic [127:0] app_data_t;

endpackage

// File: rtl/mig_app_model_wdf_fifo.sv
// Write-data FIFO for the MIG app model.
// Head word is visible combinationally while not empty.
module mig_wdf_fifo
  import mig_app_model_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  app_data_t din,
  output app_data_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  app_data_t   mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mig_app_model.sv
// Synthesizable responder for the MIG user interface.
// Calibration delay, throttling, write buffering, fixed-latency reads.
module mig_app_model
  import mig_app_model_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int CALIB_CYCLES = 16,
  parameter int RD_LATENCY   = 4,
  parameter int BUSY_EVERY   = 4,
  parameter int WDF_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         app_en,
  input  logic [2:0]   app_cmd,
  input  logic [26:0]  app_addr,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete,
  output logic         cmd_err
);

  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int TW = $clog2(BUSY_EVERY + 2);

  app_data_t mem [2**ADDR_BITS];

  logic [CW-1:0]        calib_cnt;
  logic                 calib;
  logic [TW-1:0]        thr_cnt;
  logic                 bubble;
  logic                 wr_pend;
  logic [ADDR_BITS-1:0] pend_idx;
  logic                 err;
  logic [RD_LATENCY-1:0] rd_vld;
  app_data_t            rd_pipe [RD_LATENCY];

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  app_data_t            fifo_dout;

  logic                 accept;
  logic                 beat;
  logic                 is_wr;
  logic                 is_rd;
  logic                 is_bad;
  logic                 wr_fifo;
  logic                 wr_byp;
  logic                 wr_late;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] idx;
  logic [ADDR_BITS-1:0] mem_idx;
  app_data_t            mem_din;
  logic                 unused;

  // BL8 at 4:1 means every beat is the last one.
  assign unused = ^{app_wdf_end,
                    app_addr[26:ADDR_BITS+3],
                    app_addr[2:0]};

  assign app_rdy     = calib & ~bubble & ~wr_pend;
  assign app_wdf_rdy = calib & ~fifo_full;

  assign accept = app_en & app_rdy;
  assign beat   = app_wdf_wren & app_wdf_rdy;
  assign idx    = app_addr[ADDR_BITS+2:3];
  assign is_wr  = accept & (app_cmd == APP_CMD_WRITE);
  assign is_rd  = accept & (app_cmd == APP_CMD_READ);
  assign is_bad = accept & ~is_wr & ~is_rd;

  assign wr_fifo = is_wr & ~fifo_empty;
  assign wr_byp  = is_wr & fifo_empty & beat;
  assign wr_late = wr_pend & beat;

  assign fifo_pop  = wr_fifo;
  assign fifo_push = beat & ~wr_byp & ~wr_late;

  assign mem_we  = wr_fifo | wr_byp | wr_late;
  assign mem_idx = wr_late ? pend_idx : idx;
  assign mem_din = wr_fifo ? fifo_dout : app_wdf_data;

  mig_wdf_fifo #(
    .DEPTH(WDF_DEPTH)
  ) u_wdf (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (app_wdf_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calib_cnt <= '0;
      calib     <= 1'b0;
    end else if (!calib) begin
      calib_cnt <= calib_cnt + 1'b1;
      if (calib_cnt == CW'(CALIB_CYCLES - 1))
        calib <= 1'b1;
    end
  end

  // Bubble lasts exactly the cycle after the wrapping acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_cnt <= '0;
      bubble  <= 1'b0;
    end else begin
      bubble <= 1'b0;
      if (accept && BUSY_EVERY != 0) begin
        if (thr_cnt == TW'(BUSY_EVERY - 1)) begin
          thr_cnt <= '0;
          bubble  <= 1'b1;
        end else begin
          thr_cnt <= thr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend  <= 1'b0;
      pend_idx <= '0;
      err      <= 1'b0;
    end else begin
      if (is_wr && fifo_empty && !beat) begin
        wr_pend  <= 1'b1;
        pend_idx <= idx;
      end else if (wr_late) begin
        wr_pend <= 1'b0;
      end
      if (is_bad) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++)
        rd_pipe[i] <= '0;
    end else begin
      rd_vld[0]  <= is_rd;
      rd_pipe[0] <= is_rd ? mem[idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign app_rd_data         = rd_pipe[RD_LATENCY-1];
  assign app_rd_data_valid   = rd_vld[RD_LATENCY-1];
  assign app_rd_data_end     = rd_vld[RD_LATENCY-1];
  assign init_calib_complete = calib;
  assign cmd_err             = err;

endmodule

// File: tb/tb_mig_app_model.sv
// Directed self-checking bench for mig_app_model.
// Hand-computed data, latency and handshake expectations.
module tb_mig_app_model;
  import mig_app_model_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         app_en = 1'b0;
  logic [2:0]   app_cmd = 3'b000;
  logic [26:0]  app_addr = '0;
  logic         app_rdy;
  logic [127:0] app_wdf_data = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         cmd_err;

  mig_app_model dut (
    .clk                 (clk),
    .reset               (reset),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .cmd_err             (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  logic [127:0] rq_d [$];
  int           rq_t [$];
  logic         rq_e [$];

  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      rq_d.push_back(app_rd_data);
      rq_t.push_back(cyc);
      rq_e.push_back(app_rd_data_end);
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_calib();
    int n = 0;
    while (!init_calib_complete && n < 40) begin
      step();
      n++;
    end
    if (!init_calib_complete) chk("calib_timeout", 0, 1);
  endtask

  task automatic issue(input logic [2:0] c,
                       input logic [26:0] a,
                       input logic wd,
                       input logic [127:0] d,
                       output int t);
    int n = 0;
    while (!app_rdy && n < 40) begin
      step();
      n++;
    end
    if (!app_rdy) chk("rdy_timeout", 0, 1);
    t = cyc;
    app_en = 1'b1;
    app_cmd = c;
    app_addr = a;
    app_wdf_wren = wd;
    app_wdf_data = d;
    step();
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
  endtask

  task automatic expect_rd(input string tag,
                           input logic [127:0] d,
                           input int t);
    if (rq_d.size() == 0) begin
      chk({tag, "_none"}, 0, 1);
    end else begin
      chk(tag, rq_d.pop_front(), d);
      chk({tag, "_lat"}, rq_t.pop_front(), t + 4);
      chk({tag, "_end"}, rq_e.pop_front(), 1);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  localparam logic [127:0] DA = 128'hAAAA_0001_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] DB = 128'hBBBB_0002_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [127:0] DE = 128'hEEEE_0005_DEAD_BEEF_CAFE_F00D_0123_4567;

  logic [127:0] dq [4];
  logic [26:0]  ra [6];
  int           ts [6];
  int           t0;
  int           t1;
  logic         early;
  logic [6:0]   rdyhist;
  int           acc;
  int           ncy;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dq[0] = 128'hD000_0000_0000_0000_0000_0000_0000_0010;
    dq[1] = 128'hD111_1111_1111_1111_1111_1111_1111_1121;
    dq[2] = 128'hD222_2222_2222_2222_2222_2222_2222_2232;
    dq[3] = 128'hD333_3333_3333_3333_3333_3333_3333_3343;
    ra = '{27'h00, 27'h08, 27'h10, 27'h18, 27'h20, 27'h00};

    step();
    step();
    chk("rst_rdy", app_rdy, 0);
    chk("rst_wdf_rdy", app_wdf_rdy, 0);
    chk("rst_valid", app_rd_data_valid, 0);
    chk("rst_end", app_rd_data_end, 0);
    chk("rst_data", app_rd_data, 0);
    chk("rst_calib", init_calib_complete, 0);
    chk("rst_cmd_err", cmd_err, 0);

    reset = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16)
        early = early | init_calib_complete | app_rdy | app_wdf_rdy;
      if (k == 15) chk("calib_at_15", init_calib_complete, 0);
    end
    chk("early_rdy", early, 0);
    chk("calib_at_16", init_calib_complete, 1);
    chk("rdy_after_calib", app_rdy, 1);
    chk("wdf_rdy_after_calib", app_wdf_rdy, 1);

    // same-cycle write data, then back-to-back reads
    issue(APP_CMD_WRITE, 27'h00, 1'b1, DA, t0);
    issue(APP_CMD_WRITE, 27'h10, 1'b1, DB, t0);
    issue(APP_CMD_READ, 27'h00, 1'b0, '0, t0);
    issue(APP_CMD_READ, 27'h10, 1'b0, '0, t1);
    chk("rd_b2b_issue", t1, t0 + 1);
    drain(8);
    expect_rd("rd_A", DA, t0);
    expect_rd("rd_B", DB, t1);

    // data before commands
    chk("wdf_rdy_empty", app_wdf_rdy, 1);
    for (int i = 0; i < 4; i++) begin
      app_wdf_wren = 1'b1;
      app_wdf_data = dq[i];
      step();
    end
    app_wdf_wren = 1'b0;
    chk("wdf_full", app_wdf_rdy, 0);
    for (int i = 0; i < 4; i++)
      issue(APP_CMD_WRITE, ra[i], 1'b0, '0, t0);
    chk("wdf_rdy_drained", app_wdf_rdy, 1);
    for (int i = 3; i >= 0; i--)
      issue(APP_CMD_READ, ra[i], 1'b0, '0, ts[i]);
    drain(10);
    for (int i = 3; i >= 0; i--)
      expect_rd($sformatf("rd_q%0d", i), dq[i], ts[i]);

    // command before data
    issue(APP_CMD_WRITE, 27'h20, 1'b0, '0, t0);
    chk("pend_rdy0", app_rdy, 0);
    step();
    chk("pend_rdy1", app_rdy, 0);
    step();
    chk("pend_rdy2", app_rdy, 0);
    app_wdf_wren = 1'b1;
    app_wdf_data = DE;
    step();
    app_wdf_wren = 1'b0;
    chk("pend_clear", app_rdy, 1);
    issue(APP_CMD_READ, 27'h20, 1'b0, '0, t0);
    drain(8);
    expect_rd("rd_late", DE, t0);

    // throttle from a fresh counter
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_calib();
    acc = 0;
    ncy = 0;
    rdyhist = '0;
    app_en = 1'b1;
    app_cmd = APP_CMD_READ;
    while (acc < 6 && ncy < 7) begin
      app_addr = ra[acc];
      rdyhist[ncy] = app_rdy;
      if (app_rdy) begin
        ts[acc] = cyc;
        acc++;
      end
      step();
      ncy++;
    end
    app_en = 1'b0;
    chk("thr_accepts", acc, 6);
    chk("thr_cycles", ncy, 7);
    chk("thr_pattern", rdyhist, 7'b1101111);
    drain(10);
    expect_rd("thr_0", dq[0], ts[0]);
    expect_rd("thr_1", dq[1], ts[1]);
    expect_rd("thr_2", dq[2], ts[2]);
    expect_rd("thr_3", dq[3], ts[3]);
    expect_rd("thr_4", DE, ts[4]);
    expect_rd("thr_5", dq[0], ts[5]);

    // illegal command
    chk("err_before", cmd_err, 0);
    issue(3'b010, 27'h00, 1'b0, '0, t0);
    chk("err_set", cmd_err, 1);
    chk("err_no_pend", app_rdy, 1);
    drain(3);
    chk("err_sticky", cmd_err, 1);
    issue(APP_CMD_READ, 27'h00, 1'b0, '0, t0);
    drain(8);
    expect_rd("ram_kept", dq[0], t0);
    chk("q_empty", rq_d.size(), 0);

    // reset during a read burst
    drain(2);
    issue(APP_CMD_READ, 27'h08, 1'b0, '0, t0);
    issue(APP_CMD_READ, 27'h10, 1'b0, '0, t0);
    issue(APP_CMD_READ, 27'h18, 1'b0, '0, t0);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", app_rd_data_valid, 0);
    chk("rst_mid_err", cmd_err, 0);
    step();
    reset = 1'b0;
    drain(10);
    chk("rst_no_reads", rq_d.size(), 0);
    chk("rst_err_clear", cmd_err, 0);
    chk("rst_recal", init_calib_complete, 0);
    chk("rst_rdy_low", app_rdy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
